// File: rtl/multi_bay_meter_pkg.sv
// Shared encodings for the multi-bay parking meter: command opcodes and bay states.
package multi_bay_meter_pkg;

    typedef logic [2:0] cmd_op_t;
    typedef logic [1:0] bay_state_t;

    localparam cmd_op_t OP_ADD_A    = 3'd0;
    localparam cmd_op_t OP_ADD_B    = 3'd1;
    localparam cmd_op_t OP_ADD_C    = 3'd2;
    localparam cmd_op_t OP_ADD_D    = 3'd3;
    localparam cmd_op_t OP_PRESET_A = 3'd4;
    localparam cmd_op_t OP_PRESET_B = 3'd5;
    localparam cmd_op_t OP_CLEAR    = 3'd6;
    localparam cmd_op_t OP_NOP      = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACTIVE  = 2'd1;
    localparam logic [1:0] ST_LOW     = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

endpackage

// File: rtl/multi_bay_meter_if.sv
// Command and display bus of the multi-bay meter; master drives commands, slave is the meter core.
interface multi_bay_meter_if #(
    parameter int NUM_BAYS = 4,
    parameter int SEC_W    = 14
);
    localparam int BAY_W = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1;

    logic                cmd_valid;
    logic [BAY_W-1:0]    cmd_bay;
    logic [2:0]          cmd_op;
    logic                cmd_ack;
    logic [BAY_W-1:0]    disp_bay;
    logic [SEC_W-1:0]    disp_seconds;
    logic                disp_blank;
    logic [NUM_BAYS-1:0] bay_low;
    logic [NUM_BAYS-1:0] bay_expired;
    logic                sec_tick;

    modport master (
        output cmd_valid, cmd_bay, cmd_op, disp_bay,
        input  cmd_ack, disp_seconds, disp_blank, bay_low, bay_expired, sec_tick
    );

    modport slave (
        input  cmd_valid, cmd_bay, cmd_op, disp_bay,
        output cmd_ack, disp_seconds, disp_blank, bay_low, bay_expired, sec_tick
    );

endinterface

// File: rtl/multi_bay_meter_bay.sv
// One parking bay: seconds register plus IDLE/ACTIVE/LOW/EXPIRED state.
// A command in the same cycle as the tick is applied first, then decremented.
module multi_bay_meter_bay
    import multi_bay_meter_pkg::*;
#(
    parameter int SEC_W    = 14,
    parameter int MAX_SEC  = 9999,
    parameter int LOW_SEC  = 180,
    parameter int ADD_A    = 60,
    parameter int ADD_B    = 120,
    parameter int ADD_C    = 180,
    parameter int ADD_D    = 300,
    parameter int PRESET_A = 16,
    parameter int PRESET_B = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_en,
    input  logic [2:0]       cmd_op,
    input  logic             tick,
    output logic [SEC_W-1:0] seconds,
    output logic [1:0]       st
);

    logic [SEC_W-1:0] sec_nxt;
    logic [1:0]       st_nxt;
    logic             load;
    logic             clr;

    // One extra bit of headroom so the sum can never wrap before clamping.
    function automatic logic [SEC_W-1:0] sat_add(input logic [SEC_W-1:0] a, input int amt);
        logic [SEC_W:0] sum;
        sum = {1'b0, a} + (SEC_W+1)'(amt);
        return (sum > (SEC_W+1)'(MAX_SEC)) ? SEC_W'(MAX_SEC) : sum[SEC_W-1:0];
    endfunction

    function automatic logic [1:0] classify(input logic [SEC_W-1:0] s);
        if (s == '0)
            return ST_EXPIRED;
        if (s < SEC_W'(LOW_SEC))
            return ST_LOW;
        return ST_ACTIVE;
    endfunction

    assign clr = cmd_en && (cmd_op == OP_CLEAR);

    always_comb begin
        sec_nxt = seconds;
        st_nxt  = st;
        load    = 1'b0;
        if (cmd_en) begin
            case (cmd_op)
                OP_ADD_A:    begin sec_nxt = sat_add(seconds, ADD_A); load = 1'b1; end
                OP_ADD_B:    begin sec_nxt = sat_add(seconds, ADD_B); load = 1'b1; end
                OP_ADD_C:    begin sec_nxt = sat_add(seconds, ADD_C); load = 1'b1; end
                OP_ADD_D:    begin sec_nxt = sat_add(seconds, ADD_D); load = 1'b1; end
                OP_PRESET_A: begin sec_nxt = SEC_W'(PRESET_A);        load = 1'b1; end
                OP_PRESET_B: begin sec_nxt = SEC_W'(PRESET_B);        load = 1'b1; end
                OP_CLEAR:    begin sec_nxt = '0; st_nxt = ST_IDLE; end
                default:     ;
            endcase
        end
        if (load) begin
            if (tick && (sec_nxt != '0))
                sec_nxt = sec_nxt - 1'b1;
            st_nxt = classify(sec_nxt);
        end else if (tick && !clr && ((st == ST_ACTIVE) || (st == ST_LOW))) begin
            sec_nxt = seconds - 1'b1;
            st_nxt  = classify(sec_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seconds <= '0;
            st      <= ST_IDLE;
        end else begin
            seconds <= sec_nxt;
            st      <= st_nxt;
        end
    end

endmodule

// File: rtl/multi_bay_meter.sv
// N-bay parking meter core: shared 1-s timebase, flash phase, command decode,
// per-bay timers and a registered display mux with blanking.
module multi_bay_meter
    import multi_bay_meter_pkg::*;
#(
    parameter int NUM_BAYS      = 4,
    parameter int SEC_W         = 14,
    parameter int TICKS_PER_SEC = 100,
    parameter int FLASH_HALF    = 50,
    parameter int MAX_SEC       = 9999,
    parameter int LOW_SEC       = 180,
    parameter int ADD_A         = 60,
    parameter int ADD_B         = 120,
    parameter int ADD_C         = 180,
    parameter int ADD_D         = 300,
    parameter int PRESET_A      = 16,
    parameter int PRESET_B      = 150
) (
    input logic             clk,
    input logic             rst,
    multi_bay_meter_if.slave bus
);

    localparam int BAY_W   = (NUM_BAYS > 1) ? $clog2(NUM_BAYS) : 1;
    localparam int TICK_W  = $clog2(TICKS_PER_SEC);
    localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [FLASH_W-1:0]  flash_cnt;
    logic                flash_ph;
    logic                ack_q;
    logic [SEC_W-1:0]    disp_sec_q;
    logic                disp_blank_q;
    logic [NUM_BAYS-1:0] bay_sel;
    logic [NUM_BAYS-1:0] low_vec;
    logic [NUM_BAYS-1:0] exp_vec;
    logic [SEC_W-1:0]    bay_sec [NUM_BAYS];
    logic [1:0]          bay_st  [NUM_BAYS];
    logic [SEC_W-1:0]    sel_sec;
    logic [1:0]          sel_st;

    // tick is registered off the wrap, so it is high in the cycle the bays decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            tick      <= 1'b0;
            flash_cnt <= '0;
            flash_ph  <= 1'b1;
        end else begin
            tick     <= (tick_cnt == TICK_W'(TICKS_PER_SEC - 1));
            tick_cnt <= (tick_cnt == TICK_W'(TICKS_PER_SEC - 1)) ? '0 : tick_cnt + 1'b1;
            if (flash_cnt == FLASH_W'(FLASH_HALF - 1)) begin
                flash_cnt <= '0;
                flash_ph  <= ~flash_ph;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_BAYS; i++) begin : g_bay
        assign bay_sel[i] = bus.cmd_valid && (bus.cmd_bay == BAY_W'(i));

        multi_bay_meter_bay #(
            .SEC_W(SEC_W), .MAX_SEC(MAX_SEC), .LOW_SEC(LOW_SEC),
            .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C(ADD_C), .ADD_D(ADD_D),
            .PRESET_A(PRESET_A), .PRESET_B(PRESET_B)
        ) u_bay (
            .clk     (clk),
            .rst     (rst),
            .cmd_en  (bay_sel[i]),
            .cmd_op  (bus.cmd_op),
            .tick    (tick),
            .seconds (bay_sec[i]),
            .st      (bay_st[i])
        );

        assign low_vec[i] = (bay_st[i] == ST_LOW);
        assign exp_vec[i] = (bay_st[i] == ST_EXPIRED);
    end

    // An out-of-range disp_bay matches no bay and shows an idle, unblanked zero.
    always_comb begin
        sel_sec = '0;
        sel_st  = ST_IDLE;
        for (int i = 0; i < NUM_BAYS; i++) begin
            if (bus.disp_bay == BAY_W'(i)) begin
                sel_sec = bay_sec[i];
                sel_st  = bay_st[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q        <= 1'b0;
            disp_sec_q   <= '0;
            disp_blank_q <= 1'b0;
        end else begin
            ack_q      <= (|bay_sel) && (bus.cmd_op != OP_NOP);
            disp_sec_q <= sel_sec;
            case (sel_st)
                ST_LOW:     disp_blank_q <= sel_sec[0];
                ST_EXPIRED: disp_blank_q <= ~flash_ph;
                default:    disp_blank_q <= 1'b0;
            endcase
        end
    end

    assign bus.cmd_ack      = ack_q;
    assign bus.disp_seconds = disp_sec_q;
    assign bus.disp_blank   = disp_blank_q;
    assign bus.bay_low      = low_vec;
    assign bus.bay_expired  = exp_vec;
    assign bus.sec_tick     = tick;

endmodule

// File: tb/tb_multi_bay_meter.sv
// Bench for multi_bay_meter: directed scenarios plus random traffic against a per-bay reference model.
module tb_multi_bay_meter;
    import multi_bay_meter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multi_bay_meter_if #(.NUM_BAYS(4), .SEC_W(14)) bus ();

    multi_bay_meter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: counting bays hold seconds > 0; expiry is a separate latched flag.
    typedef struct packed { int sec; bit run; bit ex; } bay_m_t;
    bay_m_t      m_bay [4];
    int          cyc;
    logic [13:0] e_disp;
    logic        e_blank;
    logic        e_ack;

    function automatic int add_amt(input int op);
        case (op)
            0: return 60;
            1: return 120;
            2: return 180;
            default: return 300;
        endcase
    endfunction

    function automatic bay_m_t step(input bay_m_t b, input bit hit, input int op, input bit tk);
        bay_m_t r;
        r = b;
        if (hit && op == 6) begin
            r.sec = 0; r.run = 1'b0; r.ex = 1'b0;
        end else if (hit && op <= 5) begin
            if (op <= 3) r.sec = (b.sec + add_amt(op) > 9999) ? 9999 : b.sec + add_amt(op);
            else         r.sec = (op == 4) ? 16 : 150;
            if (tk) r.sec = r.sec - 1;
            r.run = 1'b1; r.ex = 1'b0;
        end else if (tk && b.run) begin
            r.sec = b.sec - 1;
            if (r.sec == 0) begin r.run = 1'b0; r.ex = 1'b1; end
        end
        return r;
    endfunction

    function automatic logic blank_of(input bay_m_t b, input int c);
        if (b.run) return (b.sec < 180) ? b.sec[0] : 1'b0;
        if (b.ex)  return ((c / 50) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] low_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_bay[i].run && (m_bay[i].sec < 180);
        return v;
    endfunction

    function automatic logic [3:0] exp_vec();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_bay[i].ex;
        return v;
    endfunction

    function automatic logic tick_now();
        return (cyc > 0) && (cyc % 100 == 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cyc     <= 0;
            e_disp  <= '0;
            e_blank <= 1'b0;
            e_ack   <= 1'b0;
            for (int i = 0; i < 4; i++) m_bay[i] <= '0;
        end else begin
            cyc     <= cyc + 1;
            e_disp  <= 14'(m_bay[bus.disp_bay].sec);
            e_blank <= blank_of(m_bay[bus.disp_bay], cyc);
            e_ack   <= bus.cmd_valid && (bus.cmd_op != 3'd7);
            for (int i = 0; i < 4; i++)
                m_bay[i] <= step(m_bay[i], bus.cmd_valid && (int'(bus.cmd_bay) == i),
                                 int'(bus.cmd_op), tick_now());
        end
    end

    task automatic send(input int bay, input int op);
        bus.cmd_valid = 1'b1;
        bus.cmd_bay   = 2'(bay);
        bus.cmd_op    = 3'(op);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Advance at least one cycle, until the model's cycle index is m modulo the tick period.
    task automatic wait_cyc_mod(input int m);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((cyc > 0) && (cyc % 100 == m)) && n < 250);
        if (n >= 250) begin
            checks++; errors++;
            $display("FAIL sync_timeout got cyc %0d required phase %0d", cyc, m);
        end
    endtask

    task automatic test_reset();
        int n;
        bus.cmd_valid = 1'b0; bus.cmd_bay = '0; bus.cmd_op = 3'd7; bus.disp_bay = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.cmd_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0b required 0", bus.cmd_ack); end
        checks++; if (bus.disp_seconds !== 14'd0) begin errors++; $display("FAIL rst_disp got %0d required 0", bus.disp_seconds); end
        checks++; if (bus.disp_blank !== 1'b0) begin errors++; $display("FAIL rst_blank got %0b required 0", bus.disp_blank); end
        checks++; if (bus.bay_low !== 4'b0) begin errors++; $display("FAIL rst_low got %b required 0000", bus.bay_low); end
        checks++; if (bus.bay_expired !== 4'b0) begin errors++; $display("FAIL rst_exp got %b required 0000", bus.bay_expired); end
        checks++; if (bus.sec_tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %0b required 0", bus.sec_tick); end
        n = 0;
        while (bus.sec_tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        checks++; if (n != 100) begin errors++; $display("FAIL first_tick got %0d cycles required 100", n); end
    endtask

    task automatic test_preset_expiry();
        int ticks, n;
        bus.disp_bay = 2'd0;
        wait_cyc_mod(1);
        send(0, OP_PRESET_A);
        checks++; if (bus.cmd_ack !== 1'b1) begin errors++; $display("FAIL t1_ack got %0b required 1", bus.cmd_ack); end
        checks++; if (bus.bay_low[0] !== 1'b1) begin errors++; $display("FAIL t1_low got %0b required 1", bus.bay_low[0]); end
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd16) begin errors++; $display("FAIL t1_sec got %0d required 16", bus.disp_seconds); end
        ticks = 0; n = 0;
        while (bus.bay_expired[0] !== 1'b1 && n < 1800) begin
            if (bus.sec_tick === 1'b1) ticks++;
            @(negedge clk); n++;
        end
        checks++; if (ticks != 16) begin errors++; $display("FAIL t1_ticks_to_expire got %0d required 16", ticks); end
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd0) begin errors++; $display("FAIL t1_expired_sec got %0d required 0", bus.disp_seconds); end
        checks++; if (bus.bay_low[0] !== 1'b0) begin errors++; $display("FAIL t1_expired_low got %0b required 0", bus.bay_low[0]); end
    endtask

    task automatic test_saturate();
        bus.disp_bay = 2'd1;
        wait_cyc_mod(1);
        for (int k = 0; k < 34; k++) send(1, OP_ADD_D);
        checks++; if (bus.cmd_ack !== 1'b1) begin errors++; $display("FAIL t2_ack got %0b required 1", bus.cmd_ack); end
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd9999) begin errors++; $display("FAIL t2_sat got %0d required 9999", bus.disp_seconds); end
        checks++; if (bus.bay_low[1] !== 1'b0) begin errors++; $display("FAIL t2_low got %0b required 0", bus.bay_low[1]); end
    endtask

    task automatic test_low_boundary();
        bus.disp_bay = 2'd2;
        wait_cyc_mod(1);
        send(2, OP_ADD_C);
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd180) begin errors++; $display("FAIL t3_180 got %0d required 180", bus.disp_seconds); end
        checks++; if (bus.bay_low[2] !== 1'b0) begin errors++; $display("FAIL t3_low180 got %0b required 0", bus.bay_low[2]); end
        wait_cyc_mod(2);
        checks++; if (bus.disp_seconds !== 14'd179) begin errors++; $display("FAIL t3_179 got %0d required 179", bus.disp_seconds); end
        checks++; if (bus.bay_low[2] !== 1'b1) begin errors++; $display("FAIL t3_low179 got %0b required 1", bus.bay_low[2]); end
        send(2, OP_ADD_A);
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd239) begin errors++; $display("FAIL t3_239 got %0d required 239", bus.disp_seconds); end
        checks++; if (bus.bay_low[2] !== 1'b0) begin errors++; $display("FAIL t3_low239 got %0b required 0", bus.bay_low[2]); end
    endtask

    task automatic test_cmd_tick();
        bus.disp_bay = 2'd3;
        wait_cyc_mod(0);
        checks++; if (bus.sec_tick !== 1'b1) begin errors++; $display("FAIL t4_align got %0b required 1", bus.sec_tick); end
        send(3, OP_ADD_B);
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd119) begin errors++; $display("FAIL t4_add_tick got %0d required 119", bus.disp_seconds); end
        checks++; if (bus.bay_low[3] !== 1'b1) begin errors++; $display("FAIL t4_low got %0b required 1", bus.bay_low[3]); end
        bus.disp_bay = 2'd1;
        wait_cyc_mod(0);
        send(1, OP_ADD_D);
        @(negedge clk);
        checks++; if (bus.disp_seconds !== 14'd9998) begin errors++; $display("FAIL t4_sat_tick got %0d required 9998", bus.disp_seconds); end
    endtask

    task automatic test_flash();
        logic prev;
        int   last, toggles;
        bus.disp_bay = 2'd0;
        repeat (2) @(negedge clk);
        prev = bus.disp_blank; last = -1; toggles = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            checks++; if (bus.disp_blank !== e_blank) begin errors++; $display("FAIL t5_blank got %0b required %0b", bus.disp_blank, e_blank); end
            if (bus.disp_blank !== prev) begin
                if (last >= 0) begin
                    checks++; if (k - last != 50) begin errors++; $display("FAIL t5_period got %0d required 50", k - last); end
                end
                last = k; toggles++; prev = bus.disp_blank;
            end
        end
        checks++; if (toggles < 3) begin errors++; $display("FAIL t5_toggles got %0d required >=3", toggles); end
        send(0, OP_CLEAR);
        checks++; if (bus.bay_expired[0] !== 1'b0) begin errors++; $display("FAIL t5_clr_exp got %0b required 0", bus.bay_expired[0]); end
        @(negedge clk);
        checks++; if (bus.disp_blank !== 1'b0) begin errors++; $display("FAIL t5_clr_blank got %0b required 0", bus.disp_blank); end
        checks++; if (bus.disp_seconds !== 14'd0) begin errors++; $display("FAIL t5_clr_sec got %0d required 0", bus.disp_seconds); end
    endtask

    task automatic test_parallel_reset();
        int exp_sec [4];
        int ticks, n;
        exp_sec = '{280, 40, 0, 0};
        wait_cyc_mod(1);
        for (int b = 0; b < 4; b++) send(b, OP_CLEAR);
        send(0, OP_ADD_D); send(1, OP_ADD_A); send(2, OP_PRESET_A); send(3, OP_CLEAR);
        ticks = 0; n = 0;
        while (ticks < 20 && n < 2500) begin
            @(negedge clk); n++;
            if (bus.sec_tick === 1'b1) ticks++;
        end
        checks++; if (ticks != 20) begin errors++; $display("FAIL t6_tick_timeout got %0d required 20", ticks); end
        @(negedge clk);
        checks++; if (bus.bay_low !== 4'b0010) begin errors++; $display("FAIL t6_low got %b required 0010", bus.bay_low); end
        checks++; if (bus.bay_expired !== 4'b0100) begin errors++; $display("FAIL t6_exp got %b required 0100", bus.bay_expired); end
        for (int b = 0; b < 4; b++) begin
            bus.disp_bay = 2'(b);
            @(negedge clk);
            checks++; if (bus.disp_seconds !== 14'(exp_sec[b])) begin errors++; $display("FAIL t6_bay%0d got %0d required %0d", b, bus.disp_seconds, exp_sec[b]); end
        end
        bus.disp_bay = 2'd1;
        bus.cmd_valid = 1'b1; bus.cmd_bay = 2'd1; bus.cmd_op = OP_ADD_D;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.cmd_valid = 1'b0;
        checks++; if (bus.bay_low !== 4'b0) begin errors++; $display("FAIL t6_rst_low got %b required 0000", bus.bay_low); end
        checks++; if (bus.bay_expired !== 4'b0) begin errors++; $display("FAIL t6_rst_exp got %b required 0000", bus.bay_expired); end
        checks++; if (bus.disp_seconds !== 14'd0) begin errors++; $display("FAIL t6_rst_sec got %0d required 0", bus.disp_seconds); end
        checks++; if (bus.cmd_ack !== 1'b0) begin errors++; $display("FAIL t6_rst_ack got %0b required 0", bus.cmd_ack); end
        @(negedge clk);
        checks++; if (bus.cmd_ack !== 1'b0) begin errors++; $display("FAIL t6_dropped_ack got %0b required 0", bus.cmd_ack); end
        checks++; if (bus.disp_seconds !== 14'd0) begin errors++; $display("FAIL t6_dropped_sec got %0d required 0", bus.disp_seconds); end
    endtask

    task automatic test_random();
        int op;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            checks++; if (bus.disp_seconds !== e_disp) begin errors++; $display("FAIL rnd_sec cyc %0d got %0d required %0d", cyc, bus.disp_seconds, e_disp); end
            checks++; if (bus.disp_blank !== e_blank) begin errors++; $display("FAIL rnd_blank cyc %0d got %0b required %0b", cyc, bus.disp_blank, e_blank); end
            checks++; if (bus.cmd_ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc %0d got %0b required %0b", cyc, bus.cmd_ack, e_ack); end
            checks++; if (bus.bay_low !== low_vec()) begin errors++; $display("FAIL rnd_low cyc %0d got %b required %b", cyc, bus.bay_low, low_vec()); end
            checks++; if (bus.bay_expired !== exp_vec()) begin errors++; $display("FAIL rnd_exp cyc %0d got %b required %b", cyc, bus.bay_expired, exp_vec()); end
            checks++; if (bus.sec_tick !== tick_now()) begin errors++; $display("FAIL rnd_tick cyc %0d got %0b required %0b", cyc, bus.sec_tick, tick_now()); end
            op = int'($urandom_range(0, 9));
            bus.cmd_valid = ($urandom_range(0, 5) == 0);
            bus.cmd_bay   = 2'($urandom_range(0, 3));
            bus.cmd_op    = (op > 6) ? OP_PRESET_A : 3'(op);
            if ($urandom_range(0, 15) == 0) bus.disp_bay = 2'($urandom_range(0, 3));
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_preset_expiry();
        test_saturate();
        test_low_boundary();
        test_cmd_tick();
        test_flash();
        test_parallel_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
